// File: rtl/mtimer.sv
// Machine timer: 64-bit mtime with prescaler, 64-bit mtimecmp, registered MTIP level.
// Bus responses arrive one cycle after the request; there is no stall, so requests may issue every cycle.
module mtimer #(
   parameter int          XLEN      = 32,
   parameter int          PRESCALE  = 1,
   parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_req,
   input  logic            i_we,
   input  logic [XLEN-1:0] i_addr,
   input  logic [XLEN-1:0] i_wdata,
   output logic            o_ack,
   output logic [XLEN-1:0] o_rdata,
   output logic            o_err,
   output logic            o_tip
);

   localparam logic [2:0]  OFF_MTIME_LO = 3'd0;
   localparam logic [2:0]  OFF_MTIME_HI = 3'd1;
   localparam logic [2:0]  OFF_CMP_LO   = 3'd2;
   localparam logic [2:0]  OFF_CMP_HI   = 3'd3;
   localparam logic [2:0]  OFF_CTRL     = 3'd4;
   localparam logic [2:0]  OFF_SNAP     = 3'd5;
   localparam logic [15:0] PS_MAX       = 16'(PRESCALE - 1);

   logic [63:0] mtime_q, mtime_d;
   logic [63:0] cmp_q, cmp_d;
   logic        en_q, en_d;
   logic [15:0] pc_q, pc_d;
   logic [31:0] snap_q, snap_d;
   logic        ack_q, ack_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;
   logic        tip_q, tip_d;

   logic [2:0]  off;
   logic        wr;
   logic        rd;
   logic        tick;
   logic [31:0] rmux;

   // Upper address bits are decoded outside; byte lanes are ignored.
   logic unused_bits;
   assign unused_bits = ^{i_addr[XLEN-1:5], i_addr[1:0], BASE_ADDR[0]};

   assign off = i_addr[4:2];
   assign wr  = i_req & i_we;
   assign rd  = i_req & ~i_we;

   always_comb begin
      tick = en_q && (pc_q == PS_MAX);
      pc_d = pc_q;
      if (en_q) begin
         pc_d = tick ? 16'd0 : pc_q + 16'd1;
      end
   end

   // A software write to either mtime half overrides the tick for that cycle.
   always_comb begin
      mtime_d = mtime_q + {63'd0, tick};
      cmp_d   = cmp_q;
      en_d    = en_q;
      snap_d  = snap_q;
      if (wr) begin
         case (off)
            OFF_MTIME_LO: mtime_d = {mtime_q[63:32], i_wdata[31:0]};
            OFF_MTIME_HI: mtime_d = {i_wdata[31:0], mtime_q[31:0]};
            OFF_CMP_LO:   cmp_d   = {cmp_q[63:32], i_wdata[31:0]};
            OFF_CMP_HI:   cmp_d   = {i_wdata[31:0], cmp_q[31:0]};
            OFF_CTRL:     en_d    = i_wdata[0];
            default:      ;
         endcase
      end
      if (rd && (off == OFF_MTIME_LO)) begin
         snap_d = mtime_q[63:32];
      end
   end

   always_comb begin
      rmux = 32'd0;
      case (off)
         OFF_MTIME_LO: rmux = mtime_q[31:0];
         OFF_MTIME_HI: rmux = mtime_q[63:32];
         OFF_CMP_LO:   rmux = cmp_q[31:0];
         OFF_CMP_HI:   rmux = cmp_q[63:32];
         OFF_CTRL:     rmux = {31'd0, en_q};
         OFF_SNAP:     rmux = snap_q;
         default:      rmux = 32'd0;
      endcase
   end

   always_comb begin
      ack_d   = i_req;
      err_d   = i_req && ((off > OFF_SNAP) || (i_we && (off == OFF_SNAP)));
      rdata_d = rd ? rmux : 32'd0;
      tip_d   = (mtime_q >= cmp_q);
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         mtime_q <= 64'd0;
         cmp_q   <= 64'hFFFF_FFFF_FFFF_FFFF;
         en_q    <= 1'b1;
         pc_q    <= 16'd0;
         snap_q  <= 32'd0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= 32'd0;
         tip_q   <= 1'b0;
      end else begin
         mtime_q <= mtime_d;
         cmp_q   <= cmp_d;
         en_q    <= en_d;
         pc_q    <= pc_d;
         snap_q  <= snap_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         tip_q   <= tip_d;
      end
   end

   assign o_ack   = ack_q;
   assign o_err   = err_q;
   assign o_rdata = {{(XLEN-32){1'b0}}, rdata_q};
   assign o_tip   = tip_q;

endmodule

// File: tb/tb_mtimer.sv
// Bench for mtimer: two instances (PRESCALE 1 and 4) checked against a behavioural model.
module tb_mtimer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic req0 = 1'b0, req1 = 1'b0, we = 1'b0;
   logic [31:0] addr = 32'd0, wdata = 32'd0;
   logic [1:0] ack, err, tip;
   logic [1:0][31:0] rdata;

   always #5 clk = ~clk;

   mtimer #(.XLEN(32), .PRESCALE(1), .BASE_ADDR(32'h0200_0000)) u_p1 (
      .i_clk(clk), .i_rst(rst_n), .i_req(req0), .i_we(we), .i_addr(addr), .i_wdata(wdata),
      .o_ack(ack[0]), .o_rdata(rdata[0]), .o_err(err[0]), .o_tip(tip[0]));
   mtimer #(.XLEN(32), .PRESCALE(4), .BASE_ADDR(32'h0200_0000)) u_p4 (
      .i_clk(clk), .i_rst(rst_n), .i_req(req1), .i_we(we), .i_addr(addr), .i_wdata(wdata),
      .o_ack(ack[1]), .o_rdata(rdata[1]), .o_err(err[1]), .o_tip(tip[1]));

   int total = 0;
   int bad = 0;

   // Reference model: mtime counts enabled cycles, ticking every PS-th one.
   int          ps [2] = '{1, 4};
   logic [63:0] m_time [2];
   logic [63:0] m_cmp  [2];
   logic        m_en   [2];
   int          m_encyc[2];
   logic [31:0] m_snap [2];
   logic        m_tip  [2];
   logic        m_ack  [2];
   logic        m_err  [2];
   logic [31:0] m_rdata[2];

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         m_time[s] = 64'd0; m_cmp[s] = '1; m_en[s] = 1'b1; m_encyc[s] = 0;
         m_snap[s] = 32'd0; m_tip[s] = 1'b0; m_ack[s] = 1'b0; m_err[s] = 1'b0; m_rdata[s] = 32'd0;
      end
   endtask

   function automatic logic [31:0] reg_read(int s, int off);
      case (off)
         0: return m_time[s][31:0];
         1: return m_time[s][63:32];
         2: return m_cmp[s][31:0];
         3: return m_cmp[s][63:32];
         4: return {31'd0, m_en[s]};
         5: return m_snap[s];
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_edge(int s, logic rq, logic w, int off, logic [31:0] d);
      logic [63:0] t_old;
      logic [63:0] t_new;
      t_old = m_time[s];
      m_tip[s]   = (t_old >= m_cmp[s]);
      m_ack[s]   = rq;
      m_err[s]   = rq && (off >= 6 || (w && off == 5));
      m_rdata[s] = (rq && !w) ? reg_read(s, off) : 32'd0;
      t_new = t_old;
      if (m_en[s]) begin
         m_encyc[s]++;
         if (m_encyc[s] % ps[s] == 0) t_new = t_old + 64'd1;
      end
      if (rq && w) begin
         case (off)
            0: t_new = {t_old[63:32], d};
            1: t_new = {d, t_old[31:0]};
            2: m_cmp[s] = {m_cmp[s][63:32], d};
            3: m_cmp[s] = {d, m_cmp[s][31:0]};
            4: m_en[s] = d[0];
            default: ;
         endcase
      end
      if (rq && !w && off == 0) m_snap[s] = t_old[63:32];
      m_time[s] = t_new;
   endtask

   task automatic cyc(int s, logic rq, logic w, int off, logic [31:0] d);
      req0 = (s == 0) && rq;
      req1 = (s == 1) && rq;
      we = w;
      addr = 32'h0200_0000 | (32'(off) << 2) | 32'($urandom_range(0, 3));
      wdata = d;
      @(posedge clk);
      model_edge(0, (s == 0) && rq, w, off, d);
      model_edge(1, (s == 1) && rq, w, off, d);
      #1;
      req0 = 1'b0; req1 = 1'b0; we = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      for (int s = 0; s < 2; s++) begin
         total++;
         if (ack[s] !== 1'b0 || tip[s] !== 1'b0 || err[s] !== 1'b0 || rdata[s] !== 32'd0) begin
            bad++;
            $display("FAIL reset_outs dut=%0d got ack=%b tip=%b err=%b rdata=%h exp all 0", s, ack[s], tip[s], err[s], rdata[s]);
         end
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      cyc(1, 1, 0, 4, 0);
      total++;
      if (ack[1] !== 1'b1 || rdata[1] !== 32'd1) begin
         bad++; $display("FAIL reset_ctrl got ack=%b rdata=%h exp ack=1 rdata=00000001", ack[1], rdata[1]);
      end
      cyc(1, 1, 0, 3, 0);
      total++;
      if (rdata[1] !== 32'hFFFF_FFFF) begin
         bad++; $display("FAIL reset_cmp_hi got=%h exp=ffffffff", rdata[1]);
      end
      cyc(1, 1, 0, 1, 0);
      total++;
      if (rdata[1] !== 32'd0 || rdata[1] !== m_rdata[1]) begin
         bad++; $display("FAIL reset_mtime_hi got=%h exp=00000000", rdata[1]);
      end
   endtask

   task automatic test_tip();
      do_reset();
      cyc(0, 1, 1, 2, 32'd5);
      cyc(0, 1, 1, 3, 32'd0);
      for (int i = 0; i < 12; i++) begin
         total++;
         if (tip[0] !== m_tip[0]) begin
            bad++; $display("FAIL tip_rise cyc=%0d got=%b exp=%b", i, tip[0], m_tip[0]);
         end
         cyc(0, 0, 0, 0, 0);
      end
      total++;
      if (tip[0] !== 1'b1) begin
         bad++; $display("FAIL tip_held got=%b exp=1", tip[0]);
      end
   endtask

   task automatic test_cmp_write();
      cyc(0, 1, 1, 2, 32'd100);
      total++;
      if (tip[0] !== 1'b1) begin
         bad++; $display("FAIL tip_at_write got=%b exp=1", tip[0]);
      end
      cyc(0, 0, 0, 0, 0);
      total++;
      if (tip[0] !== 1'b0) begin
         bad++; $display("FAIL tip_clear got=%b exp=0", tip[0]);
      end
      for (int i = 0; i < 100; i++) begin
         cyc(0, 0, 0, 0, 0);
         total++;
         if (tip[0] !== m_tip[0]) begin
            bad++; $display("FAIL tip_rearm cyc=%0d got=%b exp=%b", i, tip[0], m_tip[0]);
         end
      end
      total++;
      if (tip[0] !== 1'b1) begin
         bad++; $display("FAIL tip_reassert got=%b exp=1", tip[0]);
      end
   endtask

   task automatic test_snapshot();
      cyc(0, 1, 1, 0, 32'hFFFF_FFFE);
      cyc(0, 1, 1, 1, 32'd0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      total++;
      if (rdata[0] !== 32'hFFFF_FFFF || rdata[0] !== m_rdata[0]) begin
         bad++; $display("FAIL snap_lo got=%h exp=ffffffff", rdata[0]);
      end
      repeat (3) cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 0, 5, 0);
      total++;
      if (rdata[0] !== 32'd0 || err[0] !== 1'b0) begin
         bad++; $display("FAIL snap_hi got=%h err=%b exp=00000000 err=0", rdata[0], err[0]);
      end
      cyc(0, 1, 0, 1, 0);
      total++;
      if (rdata[0] !== 32'd1) begin
         bad++; $display("FAIL live_hi got=%h exp=00000001", rdata[0]);
      end
   endtask

   task automatic test_prescale();
      logic [31:0] r [12];
      for (int i = 0; i < 12; i++) begin
         cyc(1, 1, 0, 0, 0);
         r[i] = rdata[1];
         total++;
         if (rdata[1] !== m_rdata[1]) begin
            bad++; $display("FAIL ps_run cyc=%0d got=%h exp=%h", i, rdata[1], m_rdata[1]);
         end
      end
      for (int i = 0; i < 8; i++) begin
         total++;
         if (r[i+4] - r[i] !== 32'd1) begin
            bad++; $display("FAIL ps_step i=%0d got delta=%0d exp 1", i, r[i+4] - r[i]);
         end
      end
      cyc(1, 1, 1, 4, 32'd0);
      cyc(1, 1, 0, 0, 0);
      r[0] = rdata[1];
      for (int i = 0; i < 20; i++) begin
         cyc(1, 1, 0, 0, 0);
         total++;
         if (rdata[1] !== r[0] || rdata[1] !== m_rdata[1]) begin
            bad++; $display("FAIL ps_hold cyc=%0d got=%h exp=%h", i, rdata[1], r[0]);
         end
      end
      cyc(1, 1, 1, 4, 32'd1);
      for (int i = 0; i < 10; i++) begin
         cyc(1, 1, 0, 0, 0);
         total++;
         if (rdata[1] !== m_rdata[1]) begin
            bad++; $display("FAIL ps_resume cyc=%0d got=%h exp=%h", i, rdata[1], m_rdata[1]);
         end
      end
   endtask

   task automatic test_errors();
      cyc(0, 1, 0, 6, 0);
      total++;
      if (ack[0] !== 1'b1 || err[0] !== 1'b1 || rdata[0] !== 32'd0) begin
         bad++; $display("FAIL err_rd18 got ack=%b err=%b rdata=%h exp 1 1 0", ack[0], err[0], rdata[0]);
      end
      cyc(0, 1, 1, 5, 32'hDEAD_BEEF);
      total++;
      if (ack[0] !== 1'b1 || err[0] !== 1'b1) begin
         bad++; $display("FAIL err_wr14 got ack=%b err=%b exp 1 1", ack[0], err[0]);
      end
      cyc(0, 1, 1, 7, 32'h1234_5678);
      cyc(0, 1, 0, 5, 0);
      total++;
      if (rdata[0] !== m_snap[0] || err[0] !== 1'b0) begin
         bad++; $display("FAIL err_nochg got=%h exp=%h", rdata[0], m_snap[0]);
      end
      cyc(0, 1, 0, 0, 0);
      total++;
      if (ack[0] !== 1'b1 || rdata[0] !== m_rdata[0]) begin
         bad++; $display("FAIL b2b_first got ack=%b rdata=%h exp 1 %h", ack[0], rdata[0], m_rdata[0]);
      end
      cyc(0, 1, 0, 1, 0);
      total++;
      if (ack[0] !== 1'b1 || rdata[0] !== m_rdata[0]) begin
         bad++; $display("FAIL b2b_second got ack=%b rdata=%h exp 1 %h", ack[0], rdata[0], m_rdata[0]);
      end
      cyc(0, 0, 0, 0, 0);
      total++;
      if (ack[0] !== 1'b0 || rdata[0] !== 32'd0) begin
         bad++; $display("FAIL b2b_idle got ack=%b rdata=%h exp 0 0", ack[0], rdata[0]);
      end
   endtask

   task automatic test_random();
      int s, off;
      logic rq, w;
      logic [31:0] d;
      for (int i = 0; i < 400; i++) begin
         s = $urandom_range(0, 1);
         rq = ($urandom_range(0, 9) < 7);
         w = ($urandom_range(0, 3) == 0);
         off = $urandom_range(0, 7);
         d = $urandom;
         if (off == 4 && $urandom_range(0, 1) == 1) d[0] = 1'b1;
         if (off == 1 || off == 3) d = 32'($urandom_range(0, 1));
         cyc(s, rq, w, off, d);
         for (int k = 0; k < 2; k++) begin
            total++;
            if (ack[k] !== m_ack[k] || err[k] !== m_err[k] || rdata[k] !== m_rdata[k] || tip[k] !== m_tip[k]) begin
               bad++;
               $display("FAIL rand i=%0d dut=%0d got ack=%b err=%b rd=%h tip=%b exp ack=%b err=%b rd=%h tip=%b",
                        i, k, ack[k], err[k], rdata[k], tip[k], m_ack[k], m_err[k], m_rdata[k], m_tip[k]);
            end
         end
      end
   endtask

   task automatic test_reset_midop();
      cyc(0, 1, 1, 2, 32'd0);
      cyc(0, 1, 1, 3, 32'd0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 0, 1, 0);
      total++;
      if (ack[0] !== 1'b1 || tip[0] !== 1'b1) begin
         bad++; $display("FAIL midop_pre got ack=%b tip=%b exp 1 1", ack[0], tip[0]);
      end
      do_reset();
      cyc(0, 1, 0, 1, 0);
      total++;
      if (rdata[0] !== 32'd0 || tip[0] !== 1'b0) begin
         bad++; $display("FAIL midop_mtime got=%h tip=%b exp 0 0", rdata[0], tip[0]);
      end
      cyc(0, 1, 0, 2, 0);
      total++;
      if (rdata[0] !== 32'hFFFF_FFFF || tip[0] !== 1'b0) begin
         bad++; $display("FAIL midop_cmp got=%h tip=%b exp ffffffff 0", rdata[0], tip[0]);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_tip();
      test_cmp_write();
      test_snapshot();
      test_prescale();
      test_errors();
      test_random();
      test_reset_midop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
